// File: rtl/framebuffer_scanout.sv
// Pixel-clock read side of the double-buffered framebuffer: VGA counts to BRAM
// address with integer upscaling, sync/blank re-alignment, and the swap handshake.
module framebuffer_scanout #(
  parameter int FRAME_WIDTH        = 512,
  parameter int FRAME_HEIGHT       = 384,
  parameter int SCALE_SHIFT        = 1,
  parameter int COORD_BITS         = 16,
  parameter int ADDR_BITS          = 18,
  parameter int BRAM_LATENCY       = 2,
  parameter int PADDED_COLOR_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COORD_BITS-1:0]         hcount_in,
  input  logic [COORD_BITS-1:0]         vcount_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          blank_in,
  input  logic [PADDED_COLOR_WIDTH-1:0] pixel_data_in,
  output logic [ADDR_BITS-1:0]          pixel_addr_out,
  output logic                          front_buffer_out,
  input  logic                          swap_req,
  output logic                          swap_ack,
  output logic                          frame_start,
  output logic [3:0]                    vga_r,
  output logic [3:0]                    vga_g,
  output logic [3:0]                    vga_b,
  output logic                          vga_hs,
  output logic                          vga_vs
);

  localparam int PIPE_DEPTH = 1 + BRAM_LATENCY;
  localparam logic [COORD_BITS:0] H_LIMIT = (COORD_BITS+1)'(FRAME_WIDTH << SCALE_SHIFT);
  localparam logic [COORD_BITS:0] V_LIMIT = (COORD_BITS+1)'(FRAME_HEIGHT << SCALE_SHIFT);
  localparam bit WIDTH_IS_POW2 = (FRAME_WIDTH & (FRAME_WIDTH - 1)) == 0;
  localparam int WIDTH_LOG2    = $clog2(FRAME_WIDTH);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
    logic oor;
  } align_t;

  // Cleared stages look like blanked, sync-inactive video.
  localparam align_t ALIGN_RESET = '{hsync: 1'b0, vsync: 1'b0, blank: 1'b1, oor: 1'b0};

  typedef enum logic {
    IDLE,
    SWAP
  } state_t;

  logic [COORD_BITS-1:0] src_x;
  logic [COORD_BITS-1:0] src_y;
  logic                  in_range;
  logic [ADDR_BITS-1:0]  row_base;
  logic [ADDR_BITS-1:0]  addr_d;
  logic [ADDR_BITS-1:0]  addr_q;
  align_t                pipe_q [PIPE_DEPTH];
  align_t                tail;
  logic [11:0]           rgb_q;
  logic                  hs_n_q;
  logic                  vs_n_q;
  state_t                state_q;
  logic                  front_q;
  logic                  swap_ack_q;
  logic                  frame_start_q;
  logic                  vsync_prev_q;
  logic                  vsync_rise;
  logic                  unused_upper;

  assign unused_upper = ^pixel_data_in[PADDED_COLOR_WIDTH-1:12];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    row_base = '0;
    src_x    = hcount_in >> SCALE_SHIFT;
    src_y    = vcount_in >> SCALE_SHIFT;
    in_range = ({1'b0, hcount_in} < H_LIMIT) && ({1'b0, vcount_in} < V_LIMIT);
    if (WIDTH_IS_POW2) begin
      row_base = ADDR_BITS'(src_y) << WIDTH_LOG2;
    end else begin
      row_base = ADDR_BITS'(src_y) * ADDR_BITS'(FRAME_WIDTH);
    end
    addr_d = in_range ? row_base + ADDR_BITS'(src_x) : '0;
  end

  // Address register plus sync/blank/oor delay line matching the BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_q[i] <= ALIGN_RESET;
      end
    end else begin
      // NOTE: registers use <= so each stage samples pre-edge values whatever the statement order.
      addr_q    <= addr_d;
      pipe_q[0] <= '{hsync: hsync_in, vsync: vsync_in, blank: blank_in, oor: ~in_range};
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tail = pipe_q[PIPE_DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q  <= '0;
      hs_n_q <= 1'b1;
      vs_n_q <= 1'b1;
    end else begin
      hs_n_q <= ~tail.hsync;
      vs_n_q <= ~tail.vsync;
      if (tail.blank || tail.oor) begin
        rgb_q <= '0;
      end else begin
        rgb_q <= pixel_data_in[11:0];
      end
    end
  end

  assign vsync_rise = vsync_in & ~vsync_prev_q;

  // Swap only on a vsync rising edge, and only once per request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      front_q       <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      vsync_prev_q  <= 1'b0;
    end else begin
      vsync_prev_q  <= vsync_in;
      frame_start_q <= vsync_rise;
      swap_ack_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (vsync_rise && swap_req) begin
            state_q    <= SWAP;
            front_q    <= ~front_q;
            swap_ack_q <= 1'b1;
          end
        end
        SWAP: begin
          if (!swap_req) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign pixel_addr_out   = addr_q;
  assign front_buffer_out = front_q;
  assign swap_ack         = swap_ack_q;
  assign frame_start      = frame_start_q;
  assign vga_r            = rgb_q[11:8];
  assign vga_g            = rgb_q[7:4];
  assign vga_b            = rgb_q[3:0];
  assign vga_hs           = hs_n_q;
  assign vga_vs           = vs_n_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Randomized and directed bench for framebuffer_scanout against a cycle-history
// reference model that derives every output from the input history.
module tb_framebuffer_scanout;

  localparam int FW  = 512;
  localparam int FH  = 384;
  localparam int SS  = 1;
  localparam int CB  = 16;
  localparam int AB  = 18;
  localparam int BL  = 2;
  localparam int PW  = 16;
  localparam int LAT = BL + 2;
  localparam int N   = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [CB-1:0] hcount_in;
  logic [CB-1:0] vcount_in;
  logic          hsync_in;
  logic          vsync_in;
  logic          blank_in;
  logic [PW-1:0] pixel_data_in;
  logic [AB-1:0] pixel_addr_out;
  logic          front_buffer_out;
  logic          swap_req;
  logic          swap_ack;
  logic          frame_start;
  logic [3:0]    vga_r;
  logic [3:0]    vga_g;
  logic [3:0]    vga_b;
  logic          vga_hs;
  logic          vga_vs;

  framebuffer_scanout #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .SCALE_SHIFT(SS), .COORD_BITS(CB),
    .ADDR_BITS(AB), .BRAM_LATENCY(BL), .PADDED_COLOR_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .pixel_data_in(pixel_data_in), .pixel_addr_out(pixel_addr_out),
    .front_buffer_out(front_buffer_out), .swap_req(swap_req), .swap_ack(swap_ack),
    .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs)
  );

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus for the cycle about to be driven.
  int          s_h, s_v;
  bit          s_hs, s_vs, s_bl, s_req, s_rst;
  logic [15:0] s_data;

  // Input history, one entry per driven cycle; neut marks cycles whose
  // contribution to the delayed outputs was wiped by a reset.
  int          h_hist [N];
  int          v_hist [N];
  bit          hs_hist [N];
  bit          vs_hist [N];
  bit          bl_hist [N];
  bit          req_hist [N];
  bit          rst_hist [N];
  bit          neut [N];
  logic [15:0] d_hist [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual 0x%0h, required 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit in_frame(input int h, input int v);
    return (h < FW * (2 ** SS)) && (v < FH * (2 ** SS));
  endfunction

  function automatic int exp_addr(input int h, input int v);
    if (!in_frame(h, v)) return 0;
    return ((v / (2 ** SS)) * FW + h / (2 ** SS)) % (2 ** AB);
  endfunction

  task automatic step();
    if (cyc >= N) begin
      $display("FAIL step_budget: cycle %0d exceeds history size %0d", cyc, N);
      $fatal(1, "history exhausted");
    end
    h_hist[cyc]   = s_h;
    v_hist[cyc]   = s_v;
    hs_hist[cyc]  = s_hs;
    vs_hist[cyc]  = s_vs;
    bl_hist[cyc]  = s_bl;
    req_hist[cyc] = s_req;
    rst_hist[cyc] = s_rst;
    d_hist[cyc]   = s_data;
    neut[cyc]     = 1'b0;
    if (s_rst) begin
      for (int j = cyc - (LAT - 1); j <= cyc; j++) begin
        if (j >= 0) neut[j] = 1'b1;
      end
    end
    rst           = s_rst;
    hcount_in     = CB'(s_h);
    vcount_in     = CB'(s_v);
    hsync_in      = s_hs;
    vsync_in      = s_vs;
    blank_in      = s_bl;
    pixel_data_in = s_data;
    swap_req      = s_req;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference model: advanced once per cycle on the falling edge with the
  // inputs the DUT sampled on the preceding rising edge.
  bit          m_front, m_swapping, m_ack, m_fs, m_prev_vs, m_rise;
  bit          e_hs, e_vs;
  logic [11:0] e_rgb;
  int          mk, mo;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      mk = cyc - 1;
      mo = cyc - LAT;
      if (rst_hist[mk]) begin
        m_front = 0; m_swapping = 0; m_ack = 0; m_fs = 0; m_prev_vs = 0;
      end else begin
        m_rise = vs_hist[mk] && !m_prev_vs;
        m_fs   = m_rise;
        m_ack  = 0;
        if (!m_swapping && m_rise && req_hist[mk]) begin
          m_front    = !m_front;
          m_ack      = 1;
          m_swapping = 1;
        end else if (m_swapping && !req_hist[mk]) begin
          m_swapping = 0;
        end
        m_prev_vs = vs_hist[mk];
      end
      check("addr", 32'(pixel_addr_out), rst_hist[mk] ? 0 : exp_addr(h_hist[mk], v_hist[mk]));
      check("front", 32'(front_buffer_out), 32'(m_front));
      check("swap_ack", 32'(swap_ack), 32'(m_ack));
      check("frame_start", 32'(frame_start), 32'(m_fs));
      if (mo < 0 || neut[mo]) begin
        e_hs = 1; e_vs = 1; e_rgb = '0;
      end else begin
        e_hs  = !hs_hist[mo];
        e_vs  = !vs_hist[mo];
        e_rgb = (bl_hist[mo] || !in_frame(h_hist[mo], v_hist[mo])) ? 12'h000 : d_hist[mk][11:0];
      end
      check("vga_hs", 32'(vga_hs), 32'(e_hs));
      check("vga_vs", 32'(vga_vs), 32'(e_vs));
      check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
    end
  end

  int fs_count;

  initial begin
    s_h = 0; s_v = 0; s_hs = 0; s_vs = 0; s_bl = 1; s_req = 0; s_rst = 1; s_data = '0;
    repeat (3) step();
    check("reset_addr", 32'(pixel_addr_out), 0);
    check("reset_front", 32'(front_buffer_out), 0);
    check("reset_hs", 32'(vga_hs), 1);
    check("reset_vs", 32'(vga_vs), 1);
    check("reset_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    s_rst = 0; s_bl = 0;

    s_h = 0;    s_v = 0;   step(); check("addr_0_0", 32'(pixel_addr_out), 0);
    s_h = 3;    s_v = 5;   step(); check("addr_3_5", 32'(pixel_addr_out), 1025);
    s_h = 1023; s_v = 767; step(); check("addr_1023_767", 32'(pixel_addr_out), 196607);

    s_h = 0; s_v = 0;
    for (int i = 0; i < 6; i++) begin
      s_hs = (i == 0);
      step();
      check("hs_latency", 32'(vga_hs), (i == 3) ? 0 : 1);
    end

    s_h = 6; s_v = 4;
    for (int i = 0; i < 5; i++) begin
      s_data = (i == 3) ? 16'hFABC : 16'h0000;
      step();
      if (i == 3) begin
        check("data_r", 32'(vga_r), 32'h0A);
        check("data_g", 32'(vga_g), 32'h0B);
        check("data_b", 32'(vga_b), 32'h0C);
      end
    end

    for (int i = 0; i < 4; i++) begin
      s_bl   = (i == 0);
      s_data = (i == 3) ? 16'h0FFF : 16'h0000;
      step();
      if (i == 3) check("blank_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    end

    for (int i = 0; i < 4; i++) begin
      s_h    = (i == 0) ? 1024 : 0;
      s_v    = 0;
      s_data = (i == 3) ? 16'h0FFF : 16'h0000;
      step();
      if (i == 0) check("oor_addr", 32'(pixel_addr_out), 0);
      if (i == 3) check("oor_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    end

    s_h = 10; s_v = 10; s_data = 16'h0123;
    s_req = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("swap_wait_front", 32'(front_buffer_out), 0);
    end
    s_vs = 1; step();
    check("swap1_front", 32'(front_buffer_out), 1);
    check("swap1_ack", 32'(swap_ack), 1);
    check("swap1_fs", 32'(frame_start), 1);
    step();
    check("swap1_ack_drop", 32'(swap_ack), 0);
    s_vs = 0; repeat (3) step();
    s_vs = 1; step();
    check("held_req_front", 32'(front_buffer_out), 1);
    check("held_req_ack", 32'(swap_ack), 0);
    check("held_req_fs", 32'(frame_start), 1);
    s_vs = 0; s_req = 0; repeat (2) step();
    s_req = 1; step();
    s_vs = 1; step();
    check("swap2_front", 32'(front_buffer_out), 0);
    check("swap2_ack", 32'(swap_ack), 1);
    s_req = 0;

    fs_count = 0;
    s_vs = 0; step();
    if (frame_start) fs_count++;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) begin
        s_vs = (i < 3);
        step();
        if (frame_start) fs_count++;
      end
    end
    check("frame_start_count", 32'(fs_count), 3);

    s_req = 1; s_vs = 0; step();
    s_vs = 1; step();
    s_req = 0;
    check("pre_reset_front", 32'(front_buffer_out), 1);
    s_h = 10; s_v = 10; s_bl = 0; s_hs = 1; s_data = 16'h0777;
    repeat (5) step();
    check("pre_reset_r", 32'(vga_r), 7);
    s_rst = 1; step();
    check("midreset_front", 32'(front_buffer_out), 0);
    check("midreset_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    check("midreset_hs", 32'(vga_hs), 1);
    check("midreset_vs", 32'(vga_vs), 1);
    check("midreset_ack", 32'(swap_ack), 0);
    s_rst = 0;

    for (int i = 0; i < 3000; i++) begin
      s_h = $urandom_range(0, 1100);
      s_v = $urandom_range(0, 820);
      if ($urandom_range(0, 7) == 0) s_h = ($urandom_range(0, 1) == 0) ? 1023 : 1024;
      if ($urandom_range(0, 7) == 0) s_v = ($urandom_range(0, 1) == 0) ? 767 : 768;
      s_hs   = ($urandom_range(0, 3) == 0);
      s_bl   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) s_vs = !s_vs;
      if ($urandom_range(0, 23) == 0) s_req = !s_req;
      s_rst  = ($urandom_range(0, 299) == 0);
      s_data = 16'($urandom);
      step();
    end
    s_rst = 0;
    step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
Read side of the pixel framebuffer. It runs in the pixel-clock domain and converts VGA timing counts into framebuffer BRAM read addresses, with integer upscaling and double-buffer selection. It re-aligns sync and blank to the BRAM read latency and drives the VGA colour and sync pins. It also owns the front/back buffer swap handshake with the rasterizer-side writer, so that swaps happen only at vertical sync.

Parameters:
FRAME_WIDTH, 512, framebuffer width in pixels.
FRAME_HEIGHT, 384, framebuffer height in pixels.
SCALE_SHIFT, 1, upscale factor is 2^SCALE_SHIFT in each axis.
COORD_BITS, 16, width of the hcount/vcount inputs.
ADDR_BITS, 18, width of the per-buffer pixel address.
BRAM_LATENCY, 2, read latency of the BRAM, in cycles from address to data.
PADDED_COLOR_WIDTH, 16, BRAM word width; colour is bits [11:0] as 4:4:4 RGB.

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
hcount_in  in  COORD_BITS  VGA horizontal count
vcount_in  in  COORD_BITS  VGA vertical count
hsync_in  in  1  active-high hsync from the timing generator
vsync_in  in  1  active-high vsync from the timing generator
blank_in  in  1  high outside the active video area
pixel_data_in  in  PADDED_COLOR_WIDTH  BRAM read data
pixel_addr_out  out  ADDR_BITS  BRAM read address within the front buffer
front_buffer_out  out  1  buffer currently scanned; used as the BRAM address MSB
swap_req  in  1  level request from the writer to swap buffers
swap_ack  out  1  one-cycle pulse when a swap takes effect
frame_start  out  1  one-cycle pulse on each vsync rising edge
vga_r, vga_g, vga_b  out  4 each  colour outputs
vga_hs, vga_vs  out  1 each  active-low sync outputs

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset state:
  - pixel_addr_out=0, front_buffer_out=0, swap_ack=0, frame_start=0.
  - vga_r/g/b=0, vga_hs=1, vga_vs=1.
  - All delay-pipeline stages are cleared (sync stages to 0, blank stages to 1).
  - The previous-vsync register is cleared to 0.
- Address stage (1 cycle):
  - In range means hcount_in < FRAME_WIDTH<<SCALE_SHIFT and vcount_in < FRAME_HEIGHT<<SCALE_SHIFT.
  - When in range, pixel_addr_out <= FRAME_WIDTH*(vcount_in>>SCALE_SHIFT) + (hcount_in>>SCALE_SHIFT), truncated to ADDR_BITS.
  - When out of range, pixel_addr_out <= 0 and the oor flag = 1.
  - The multiply is a shift when FRAME_WIDTH is a power of two; no DSP is required.
- Alignment:
  - hsync_in, vsync_in, blank_in and oor pass through a shift register of depth 1+BRAM_LATENCY.
  - The data output register adds 1 more cycle, so every VGA output lags its inputs by BRAM_LATENCY+2 cycles (4 at default).
- Output stage (registered):
  - vga_hs <= ~hsync_d and vga_vs <= ~vsync_d.
  - If blank_d or oor_d: r/g/b <= 0.
  - Otherwise: r <= pixel_data_in[11:8], g <= pixel_data_in[7:4], b <= pixel_data_in[3:0].
  - Bits [15:12] of pixel_data_in are ignored.
- Frame/swap state machine (states IDLE, SWAP):
  - A vsync rising edge is detected on the undelayed vsync_in, as vsync_in & ~vsync_prev.
  - On every rising edge, frame_start=1 for exactly one cycle.
  - IDLE -> SWAP on a rising edge with swap_req=1. In that same cycle front_buffer_out toggles and swap_ack pulses 1.
  - SWAP -> IDLE once swap_req=0.
  - While in SWAP, further rising edges do not swap again. The writer must drop swap_req after seeing swap_ack; a request still held never causes a double swap.
  - A swap_req asserted mid-frame waits for the next rising edge; the buffer never changes inside active video.
  - swap_req and the rising edge arriving in the same cycle counts as a request present, so the swap happens.
- Reset mid-frame: all state returns to the reset values in the next cycle. Scanout resumes with the next valid counts; alignment recovers after BRAM_LATENCY+2 cycles.
- Counter wrap (hcount/vcount returning to 0) needs no special handling, since the address is recomputed every cycle.

Test Plan:
- Address at default parameters:
  - (hcount,vcount)=(0,0) -> pixel_addr_out=0 next cycle.
  - (3,5) -> 512*2+1=1025.
  - (1023,767) -> 512*383+511=196607.
- Latency: drive hsync_in=1 for one cycle -> vga_hs=0 for exactly one cycle, 4 cycles later. pixel_data_in=16'hFABC presented at cycle 3 with blank low -> r=A, g=B, b=C at cycle 4.
- Blank and out-of-range:
  - blank_in=1 with data 16'h0FFF -> rgb=0.
  - hcount_in=1024, vcount_in=0, blank low -> pixel_addr_out=0 and rgb=0.
- Swap handshake:
  - swap_req=1 mid-frame -> no change until the vsync rising edge.
  - At the edge: front_buffer_out 0->1 and swap_ack=1 for 1 cycle.
  - Holding swap_req through the next vsync -> no second swap.
  - Drop swap_req, raise it again, next vsync -> front_buffer_out 1->0.
- frame_start: three vsync pulses -> exactly three one-cycle frame_start pulses, each aligned to a vsync_in rising cycle.
- Reset mid-frame with front_buffer_out=1 and active colour output -> next cycle front_buffer_out=0, rgb=0, vga_hs=vga_vs=1, swap_ack=0.
